fifo_stream_reader: RTL and testbench

// - Read-side engine for fifo_single_clk: pops words with rd_en and presents them downstream on a valid/ready stream.
// - Hides the FIFO's 1-cycle read latency with a 2-entry skid buffer, so throughput is 1 word/clk under back-pressure.
// - Marks burst boundaries with m_last for framed consumers.

---
 rtl/fifo_stream_reader_if.sv | 24 ++
 rtl/fifo_stream_reader.sv | 95 +++++++++
 tb/tb_fifo_stream_reader.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_stream_reader_if.sv
// Downstream valid/ready stream carrying FIFO words
// with a burst-boundary marker.
interface fifo_stream_reader_if #(
  parameter int FIFO_WIDTH = 8
);
  logic [FIFO_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_last;
  logic                  m_ready;

  modport master (
    output m_data,
    output m_valid,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_valid,
    input  m_last,
    output m_ready
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// Read engine for fifo_single_clk: 2-entry skid hides read latency.
// Optional FIFO_RD_WORDCNT_EN adds a 32-bit delivered-word counter.
module fifo_stream_reader #(
  parameter int FIFO_WIDTH = 8,
  parameter int BURST_LEN  = 4,
  parameter int BEAT_BITS  = $clog2(BURST_LEN) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FIFO_WIDTH-1:0] buf_out,
  input  logic                  buf_empty,
  output logic                  rd_en,
  fifo_stream_reader_if.master  m
`ifdef FIFO_RD_WORDCNT_EN
  ,
  output logic [31:0]           word_count
`endif
);

  logic [1:0]            occ, occ_n;
  logic                  inflight;
  logic [FIFO_WIDTH-1:0] head, head_n;
  logic [FIFO_WIDTH-1:0] tail, tail_n;
  logic [BEAT_BITS-1:0]  beat, beat_n;
  logic                  pop;
  logic                  last_beat;
  logic [2:0]            level;

  assign pop       = m.m_valid & m.m_ready;
  assign last_beat = (beat == BEAT_BITS'(BURST_LEN - 1));

  // Words held or owed after this cycle's pop; m_ready feeds rd_en.
  assign level = {1'b0, occ} + {2'b00, inflight}
               - {2'b00, pop};
  assign rd_en = !rst & !buf_empty & (level < 3'd2);

  assign m.m_valid = (occ != 2'd0);
  assign m.m_data  = head;
  assign m.m_last  = m.m_valid & last_beat;

  always_comb begin
    occ_n  = occ;
    head_n = head;
    tail_n = tail;
    beat_n = beat;
    unique case ({pop, inflight})
      2'b11: begin
        if (occ == 2'd1) begin
          head_n = buf_out;
        end else begin
          head_n = tail;
          tail_n = buf_out;
        end
      end
      2'b10: begin
        head_n = tail;
        occ_n  = occ - 2'd1;
      end
      2'b01: begin
        if (occ == 2'd0) head_n = buf_out;
        else             tail_n = buf_out;
        occ_n = occ + 2'd1;
      end
      default: ;
    endcase
    if (pop) begin
      beat_n = last_beat ? '0
             : beat + BEAT_BITS'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ      <= '0;
      inflight <= 1'b0;
      head     <= '0;
      tail     <= '0;
      beat     <= '0;
    end else begin
      occ      <= occ_n;
      inflight <= rd_en;
      head     <= head_n;
      tail     <= tail_n;
      beat     <= beat_n;
    end
  end

`ifdef FIFO_RD_WORDCNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      word_count <= '0;
    else if (pop) word_count <= word_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader with a behavioural
// 64x8 single-clock FIFO in front of it.
module tb_fifo_stream_reader;

  logic       clk;
  logic       rst;
  logic       frst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic [7:0] buf_out;
  logic       buf_empty;
  logic       rd_en;
  logic [7:0] mem [64];
  logic [5:0] wp, rp;
  int         fcnt;
`ifdef FIFO_RD_WORDCNT_EN
  logic [31:0] word_count;
`endif

  fifo_stream_reader_if #(.FIFO_WIDTH(8)) m_if ();

  fifo_stream_reader #(
    .FIFO_WIDTH(8),
    .BURST_LEN (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .buf_out   (buf_out),
    .buf_empty (buf_empty),
    .rd_en     (rd_en),
    .m         (m_if)
`ifdef FIFO_RD_WORDCNT_EN
    ,
    .word_count(word_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign buf_empty = (fcnt == 0);

  always_ff @(posedge clk or posedge frst) begin
    if (frst) begin
      wp      <= '0;
      rp      <= '0;
      fcnt    <= 0;
      buf_out <= '0;
    end else begin
      if (wr_en && fcnt < 64) begin
        mem[wp] <= wr_data;
        wp      <= wp + 6'd1;
      end
      if (rd_en && fcnt > 0) begin
        buf_out <= mem[rp];
        rp      <= rp + 6'd1;
      end
      fcnt <= fcnt + ((wr_en && fcnt < 64) ? 1 : 0)
                   - ((rd_en && fcnt > 0) ? 1 : 0);
    end
  end

  typedef struct {
    logic [7:0] d;
    logic       l;
    int         c;
  } beat_t;

  typedef struct {
    logic       wr;
    logic [7:0] wd;
    logic       rdy;
    logic       e_rd;
    logic       e_v;
    logic [7:0] e_d;
    logic       e_l;
  } vec_t;

  beat_t      got [$];
  int         n_vec;
  int         n_err;
  int         rd_cnt;
  int         cyc;
  logic       chk_stab;
  logic       hold_prev;
  logic [7:0] prev_d;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h",
               name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    frst       = 1'b1;
    wr_en      = 1'b0;
    wr_data    = '0;
    m_if.m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst  = 1'b0;
    frst = 1'b0;
  endtask

  task automatic wait_got(int n, int budget);
    int k;
    k = 0;
    while (got.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk("wait_timeout", 32'(got.size() >= n), 32'd1);
  endtask

  task automatic chk_seq(string name, logic [7:0] base,
                         int n, logic chk_last);
    for (int i = 0; i < n; i++) begin
      if (i < got.size()) begin
        chk({name, "_data"}, 32'(got[i].d),
            32'(base + 8'(i)));
        if (chk_last)
          chk({name, "_last"}, 32'(got[i].l),
              32'((i % 4) == 3));
      end
    end
  endtask

  // Negedge monitor: records pops and checks hold stability.
  initial begin
    cyc       = 0;
    rd_cnt    = 0;
    hold_prev = 1'b0;
    prev_d    = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rd_en) rd_cnt++;
      if (rst) begin
        hold_prev = 1'b0;
      end else begin
        if (chk_stab && hold_prev) begin
          chk("hold_valid", 32'(m_if.m_valid), 32'd1);
          chk("hold_data", 32'(m_if.m_data),
              32'(prev_d));
        end
        hold_prev = m_if.m_valid && !m_if.m_ready;
        prev_d    = m_if.m_data;
        if (m_if.m_valid && m_if.m_ready)
          got.push_back('{m_if.m_data, m_if.m_last, cyc});
      end
    end
  end

  initial begin
    vec_t tv [7];
    int   bad;
    logic ok;

    tv[0] = '{1'b1, 8'hB3, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
    tv[1] = '{1'b1, 8'hF0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
    tv[2] = '{1'b1, 8'hAA, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
    tv[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hB3, 1'b0};
    tv[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hF0, 1'b0};
    tv[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hAA, 1'b0};
    tv[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};

    n_vec    = 0;
    n_err    = 0;
    chk_stab = 1'b0;
    rst      = 1'b1;
    frst     = 1'b1;
    wr_en    = 1'b0;
    wr_data  = '0;
    m_if.m_ready = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    chk("rst_valid", 32'(m_if.m_valid), 32'd0);
    chk("rst_data", 32'(m_if.m_data), 32'd0);
    chk("rst_last", 32'(m_if.m_last), 32'd0);
`ifdef FIFO_RD_WORDCNT_EN
    chk("rst_wcnt", word_count, 32'd0);
`endif
    do_reset();

    // Three words: latency and ordering, cycle by cycle.
    for (int i = 0; i < 7; i++) begin
      wr_en        = tv[i].wr;
      wr_data      = tv[i].wd;
      m_if.m_ready = tv[i].rdy;
      @(negedge clk);
      chk($sformatf("v%0d_rd_en", i), 32'(rd_en),
          32'(tv[i].e_rd));
      chk($sformatf("v%0d_valid", i),
          32'(m_if.m_valid), 32'(tv[i].e_v));
      if (tv[i].e_v) begin
        chk($sformatf("v%0d_data", i),
            32'(m_if.m_data), 32'(tv[i].e_d));
        chk($sformatf("v%0d_last", i),
            32'(m_if.m_last), 32'(tv[i].e_l));
      end
      tick();
    end

    // Eight words at full rate.
    do_reset();
    got.delete();
    m_if.m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'(i + 1);
      tick();
    end
    wr_en = 1'b0;
    wait_got(8, 40);
    chk_seq("burst8", 8'h01, 8, 1'b1);
    ok = (got.size() == 8);
    for (int i = 1; i < got.size(); i++)
      if (got[i].c != got[0].c + i) ok = 1'b0;
    chk("burst8_no_bubble", 32'(ok), 32'd1);

    // Back-pressure: two pops fill the skid, then stall.
    do_reset();
    got.delete();
    rd_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'(i + 1);
      tick();
    end
    wr_en = 1'b0;
    repeat (20) tick();
    chk("bp_rd_pulses", 32'(rd_cnt), 32'd2);
    chk("bp_fifo_cnt", 32'(fcnt), 32'd8);
    chk("bp_valid", 32'(m_if.m_valid), 32'd1);
    chk("bp_head", 32'(m_if.m_data), 32'h01);
    chk("bp_no_pop", 32'(got.size()), 32'd0);
    m_if.m_ready = 1'b1;
    wait_got(10, 60);
    chk_seq("bp_drain", 8'h01, 10, 1'b0);

    // Toggling ready.
    do_reset();
    got.delete();
    chk_stab = 1'b1;
    for (int i = 0; i < 60 && got.size() < 6; i++) begin
      m_if.m_ready = (i % 2) == 0;
      wr_en        = (i < 6);
      wr_data      = 8'(8'h21 + i);
      tick();
    end
    wr_en    = 1'b0;
    chk_stab = 1'b0;
    chk("tog_count", 32'(got.size()), 32'd6);
    chk_seq("tog", 8'h21, 6, 1'b0);

    // Never written.
    do_reset();
    m_if.m_ready = 1'b1;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rd_en || m_if.m_valid) bad++;
      tick();
    end
    chk("idle_quiet", 32'(bad), 32'd0);

    // Reset mid-burst after two pops.
    do_reset();
    got.delete();
    for (int i = 0; i < 3; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'(8'hA1 + i);
      tick();
    end
    wr_en = 1'b0;
    repeat (6) tick();
    m_if.m_ready = 1'b1;
    repeat (2) tick();
    m_if.m_ready = 1'b0;
    repeat (4) tick();
    chk("mid_pops", 32'(got.size()), 32'd2);
    chk("mid_valid", 32'(m_if.m_valid), 32'd1);
    chk("mid_head", 32'(m_if.m_data), 32'hA3);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(m_if.m_valid), 32'd0);
    chk("mid_rst_last", 32'(m_if.m_last), 32'd0);
    chk("mid_rst_rd_en", 32'(rd_en), 32'd0);
`ifdef FIFO_RD_WORDCNT_EN
    chk("mid_rst_wcnt", word_count, 32'd0);
`endif
    tick();
    rst = 1'b0;
    got.delete();
    m_if.m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'(8'h31 + i);
      tick();
    end
    wr_en = 1'b0;
    wait_got(8, 40);
    chk_seq("post_rst", 8'h31, 8, 1'b1);
`ifdef FIFO_RD_WORDCNT_EN
    chk("post_rst_wcnt", word_count, 32'd8);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
